// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_pkg: shared widths, constants and the queue entry record of the prefetch unit.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: instruction-memory, hazard/redirect and IF/ID signals of the prefetch unit.
interface fetch_prefetch_unit_if;
   import fetch_pkg::*;
   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pc_plus4;
   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, stall, redirect_valid, redirect_pc
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, stall, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_prefetch_unit_queue.sv
// fetch_queue: synchronous instruction FIFO with flush and occupancy output; simultaneous
// push and pop are legal even when full.
module fetch_queue import fetch_pkg::*; #(
   parameter int QDEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  entry_t                   push_data,
   output entry_t                   head,
   output logic [$clog2(QDEPTH):0]  count
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   entry_t          mem_q [QDEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   always_comb begin
      wr_d  = flush ? '0 : push ? wr_q + 1'b1 : wr_q;
      rd_d  = flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) mem_q[wr_q] <= push_data;
   end
   assign head  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: credit-limited instruction prefetcher feeding IF/ID through fetch_queue.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt / perf_flush_cnt counters.
module fetch_prefetch_unit import fetch_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              QDEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   fetch_prefetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0]       perf_fetch_cnt,
   output logic [XLEN-1:0]       perf_flush_cnt
`endif
);
   localparam int CW = $clog2(QDEPTH) + 1;
   logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, q_count;
   logic [CW:0]     used;
   logic            redir, req_valid, accept, rsp_live, keep, if_valid, pop;
   entry_t          head, push_entry;
   assign redir     = bus.redirect_valid;
   assign used      = {1'b0, q_count} + {1'b0, outst_q};
   assign req_valid = !reset && !redir && (used < (CW+1)'(QDEPTH));
   assign accept    = req_valid && bus.imem_req_ready;
   assign rsp_live  = bus.imem_rsp_valid && (outst_q != '0);
   // rsp_pc_q tracks the oldest kept request: kept requests are contiguous from the last redirect
   assign keep       = rsp_live && !redir && (drop_q == '0);
   assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};
   assign if_valid   = q_count != '0;
   assign pop        = if_valid && !bus.stall;
   always_comb begin
      pc_d     = redir ? word_align(bus.redirect_pc) : accept ? pc_q + 32'd4 : pc_q;
      rsp_pc_d = redir ? word_align(bus.redirect_pc) : keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
      outst_d  = outst_q + CW'(accept) - CW'(rsp_live);
      drop_d   = redir ? outst_q - CW'(rsp_live)
               : (rsp_live && drop_q != '0) ? drop_q - 1'b1 : drop_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end
   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (redir),
      .push      (keep),
      .pop       (pop),
      .push_data (push_entry),
      .head      (head),
      .count     (q_count)
   );
   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.if_valid       = if_valid;
   assign bus.if_instr       = if_valid ? head.instr : NOP_INSTR;
   assign bus.if_pc          = if_valid ? head.pc : RESET_PC;
   assign bus.if_pc_plus4    = bus.if_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] fetch_cnt_q, flush_cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_q + XLEN'(accept);
         flush_cnt_q <= flush_cnt_q + XLEN'(redir);
      end
   end
   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: randomized bench with an in-order memory and a stream-level
// reference model of the instruction sequence the fetch unit must deliver.
module tb_fetch_prefetch_unit;
   localparam int          QD     = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   logic clk, reset;
   fetch_prefetch_unit_if bus();
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif
   fetch_prefetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   int          checks, errors;
   logic [31:0] mem_a[$];
   bit          mem_s[$];
   int          pending, n_fetch, n_flush, cyc;
   logic [31:0] exp_pc, exp_req;
   int          pct_rdy, pct_rsp, pct_stall, pct_redir;
   bit          force_redir, dir35;
   logic [31:0] force_target;
   bit          prev_ok, prev_rv, prev_rdy, prev_redir, prev_ifv, prev_stall;
   logic [31:0] prev_addr, prev_pc, prev_instr;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h5A5A_0000;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic cycle();
      bit rsp, acc, dlv, stale_hd, exp_rv;
      @(negedge clk);
      bus.imem_req_ready = ($urandom_range(99) < pct_rdy);
      bus.stall          = ($urandom_range(99) < pct_stall);
      bus.redirect_valid = force_redir || ($urandom_range(99) < pct_redir);
      bus.redirect_pc    = force_redir ? force_target
                         : ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      force_redir        = 1'b0;
      rsp                = (mem_a.size() != 0) && ($urandom_range(99) < pct_rsp);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_word(mem_a[0]) : $urandom;
      #1;
      exp_rv = !bus.redirect_valid && (mem_a.size() + pending < QD);
      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      chk("if_valid", 32'(bus.if_valid), 32'(pending != 0));
      if (prev_ok && prev_rv && !prev_rdy && !prev_redir && bus.imem_req_valid)
         chk("addr_hold", bus.imem_req_addr, prev_addr);
      if (prev_ok && prev_redir) chk("ifv_after_redir", 32'(bus.if_valid), 32'd0);
      if (prev_ok && prev_ifv && prev_stall && !prev_redir) begin
         chk("hold_pc", bus.if_pc, prev_pc);
         chk("hold_instr", bus.if_instr, prev_instr);
      end
      if (bus.if_valid) chk("pc_plus4", bus.if_pc_plus4, bus.if_pc + 32'd4);
      if (dir35 && cyc == 0) begin
         chk("first_req_v", 32'(bus.imem_req_valid), 32'd1);
         chk("first_req_addr", bus.imem_req_addr, RST_PC);
      end
      if (dir35 && cyc == 2) begin
         chk("first_ifv", 32'(bus.if_valid), 32'd1);
         chk("first_if_pc", bus.if_pc, RST_PC);
      end
      dlv = bus.if_valid && !bus.stall && !bus.redirect_valid;
      if (dlv) begin
         chk("if_pc", bus.if_pc, exp_pc);
         chk("if_instr", bus.if_instr, mem_word(exp_pc));
         exp_pc += 32'd4;
         if (pending > 0) pending--;
      end
      acc = bus.imem_req_valid && bus.imem_req_ready;
      if (acc) begin
         chk("req_addr", bus.imem_req_addr, exp_req);
         exp_req += 32'd4;
         n_fetch++;
      end
      if (rsp) begin
         stale_hd = mem_s[0];
         void'(mem_a.pop_front());
         void'(mem_s.pop_front());
         if (!bus.redirect_valid && !stale_hd) pending++;
      end
      if (bus.redirect_valid) begin
         foreach (mem_s[i]) mem_s[i] = 1'b1;
         pending = 0;
         exp_pc  = {bus.redirect_pc[31:2], 2'b00};
         exp_req = exp_pc;
         n_flush++;
      end
      if (acc) begin
         mem_a.push_back(bus.imem_req_addr);
         mem_s.push_back(1'b0);
      end
      prev_ok    = 1'b1;
      prev_rv    = bus.imem_req_valid;
      prev_rdy   = bus.imem_req_ready;
      prev_redir = bus.redirect_valid;
      prev_addr  = bus.imem_req_addr;
      prev_ifv   = bus.if_valid;
      prev_stall = bus.stall;
      prev_pc    = bus.if_pc;
      prev_instr = bus.if_instr;
      cyc++;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask
   // the reset cycle carries a junk response that must be ignored
   task automatic do_reset();
      @(negedge clk);
      reset              = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      #1;
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_if_instr", bus.if_instr, 32'h0000_0013);
      chk("rst_if_pc", bus.if_pc, RST_PC);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
      chk("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
      bus.imem_rsp_valid = 1'b0;
      bus.imem_req_ready = 1'b0;
      mem_a.delete();
      mem_s.delete();
      pending = 0;
      exp_pc  = RST_PC;
      exp_req = RST_PC;
      n_fetch = 0;
      n_flush = 0;
      cyc     = 0;
      prev_ok = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask
   int rdy_t[6]   = '{100, 50, 80, 20, 100, 70};
   int rsp_t[6]   = '{100, 40, 60, 90, 30, 80};
   int stall_t[6] = '{0, 30, 50, 10, 70, 20};
   int redir_t[6] = '{2, 5, 10, 3, 15, 1};
   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      force_redir  = 1'b0;
      force_target = 32'h0;
      dir35  = 1'b0;
      do_reset();
      pct_rdy = 100; pct_rsp = 100; pct_stall = 0; pct_redir = 0;
      dir35 = 1'b1;
      run(20);
      dir35 = 1'b0;
      pct_stall = 100;
      run(10);
      chk("stall_credit_out", 32'(bus.imem_req_valid), 32'd0);
      pct_stall = 0;
      run(10);
      force_redir = 1'b1; force_target = 32'h0000_0203;
      run(8);
      force_redir = 1'b1; force_target = 32'hFFFF_FFF8;
      run(8);
      for (int p = 0; p < 6; p++) begin
         pct_rdy = rdy_t[p]; pct_rsp = rsp_t[p]; pct_stall = stall_t[p]; pct_redir = redir_t[p];
         run(500);
      end
      pct_rdy = 60; pct_rsp = 50; pct_stall = 30; pct_redir = 5;
      run(37);
      do_reset();
      run(300);
      pct_redir = 60;
      run(100);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, 32'(n_fetch));
      chk("perf_flush", perf_flush_cnt, 32'(n_flush));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
